// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life generation engine.
// Border behaviour is selected by the LIFE_TORUS_EN macro in life_stepper.
package life_pkg;

  localparam int unsigned TICK_W   = 16;
  localparam int unsigned DEF_ROWS = 8;
  localparam int unsigned DEF_COLS = 8;
  localparam int unsigned NBR_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  // Population count of the eight neighbour bits (result 0..8).
  function automatic logic [NBR_W-1:0] bit_counter(input logic [7:0] bits);
    logic [NBR_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + NBR_W'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/life_cell.sv
// One board cell: counts the live neighbours in its 3x3 window and
// produces the cell's state for the next generation.
module life_cell
  import life_pkg::*;
(
  input  logic [8:0] window,
  output logic       next_c
);

  logic [7:0]       nbrs;
  logic [NBR_W-1:0] n;

  // Bit 4 of the window is the cell itself; the rest are its neighbours.
  assign nbrs   = {window[8:5], window[3:0]};
  assign n      = bit_counter(nbrs);
  assign next_c = (n == NBR_W'(3)) | (window[4] & (n == NBR_W'(2)));

endmodule

// File: rtl/life_stepper.sv
// Game of Life board: row-wise load, periodic generation update, auto-halt.
// Define LIFE_TORUS_EN for a toroidal board; otherwise off-board cells are dead.
module life_stepper
  import life_pkg::*;
#(
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned COLS = DEF_COLS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  input  logic [$clog2(ROWS)-1:0]  load_row,
  input  logic [COLS-1:0]          load_data,
  output logic                     load_ready,
  input  logic                     start,
  input  logic                     stop,
  input  logic [TICK_W-1:0]        ticks_per_gen,
  output logic [ROWS*COLS-1:0]     cells,
  output logic [TICK_W-1:0]        generation,
  output logic                     busy,
  output logic                     stable
);

  localparam int unsigned NCELL = ROWS * COLS;

  state_e              state_q, state_d;
  logic [NCELL-1:0]    cells_q, cells_d;
  logic [TICK_W-1:0]   gen_q, gen_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [TICK_W-1:0]   period_m1_c;
  logic                update_c;
  logic                load_c;
  logic [NCELL-1:0]    next_board_c;

  // Per-cell neighbourhood gathering; border cells wrap or read as dead.
  for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
    for (genvar c = 0; c < int'(COLS); c++) begin : g_col
      logic [8:0] window;
      for (genvar dy = 0; dy < 3; dy++) begin : g_dy
        for (genvar dx = 0; dx < 3; dx++) begin : g_dx
          localparam int RR = r + dy - 1;
          localparam int CC = c + dx - 1;
`ifdef LIFE_TORUS_EN
          localparam int RW = (RR + int'(ROWS)) % int'(ROWS);
          localparam int CW = (CC + int'(COLS)) % int'(COLS);
          assign window[dy*3+dx] = cells_q[RW*int'(COLS)+CW];
`else
          if (RR < 0 || RR >= int'(ROWS) || CC < 0 || CC >= int'(COLS)) begin : g_out
            assign window[dy*3+dx] = 1'b0;
          end else begin : g_in
            assign window[dy*3+dx] = cells_q[RR*int'(COLS)+CC];
          end
`endif
        end
      end
      life_cell u_cell (
        .window (window),
        .next_c (next_board_c[r*int'(COLS)+c])
      );
    end
  end

  always_comb begin
    state_d     = state_q;
    cells_d     = cells_q;
    gen_d       = gen_q;
    tick_d      = tick_q;
    period_m1_c = (ticks_per_gen == '0) ? '0 : ticks_per_gen - TICK_W'(1);
    update_c    = (state_q == RUN) && (tick_q == period_m1_c);
    load_c      = load_valid && (state_q != RUN);

    if (stop) begin
      state_d = IDLE;
    end else if (update_c) begin
      tick_d = '0;
      if (next_board_c != cells_q) begin
        cells_d = next_board_c;
        gen_d   = gen_q + TICK_W'(1);
      end else begin
        state_d = HALT;
      end
    end else begin
      if (state_q == RUN) begin
        tick_d = tick_q + TICK_W'(1);
      end
      if (load_c) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          if (int'(load_row) == r) begin
            cells_d[r*int'(COLS) +: COLS] = load_data;
          end
        end
        if (state_q == HALT) begin
          state_d = IDLE;
        end
      end
      // Start overrides the HALT->IDLE move of a simultaneous load.
      if (start && (state_q != RUN)) begin
        state_d = RUN;
        tick_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cells_q <= '0;
      gen_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      cells_q <= cells_d;
      gen_q   <= gen_d;
      tick_q  <= tick_d;
    end
  end

  assign load_ready = (state_q != RUN);
  assign busy       = (state_q == RUN);
  assign stable     = (state_q == HALT);
  assign cells      = cells_q;
  assign generation = gen_q;

endmodule

// File: tb/tb_life_stepper.sv
// Scoreboard bench for life_stepper on an 8x8 board (plane or torus via LIFE_TORUS_EN).
module tb_life_stepper;

  localparam logic [2:0] F_IDLE = 3'b100;
  localparam logic [2:0] F_RUN  = 3'b010;
  localparam logic [2:0] F_HALT = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [2:0]  load_row;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        start;
  logic        stop;
  logic [15:0] ticks_per_gen;
  logic [63:0] cells;
  logic [15:0] generation;
  logic        busy;
  logic        stable;

  always #5 clk = ~clk;

  life_stepper #(.ROWS(8), .COLS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_row      (load_row),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .start         (start),
    .stop          (stop),
    .ticks_per_gen (ticks_per_gen),
    .cells         (cells),
    .generation    (generation),
    .busy          (busy),
    .stable        (stable)
  );

  typedef struct {
    string       tag;
    logic [63:0] cells;
    logic [15:0] gen;
    logic [2:0]  flags;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [63:0] c, input logic [15:0] g,
                          input logic [2:0] f);
    exp_t e;
    e.tag = tag; e.cells = c; e.gen = g; e.flags = f;
    exp_q.push_back(e);
  endtask

  task automatic clr_inputs();
    load_valid = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  // Advance one edge, then compare the DUT against the oldest expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({e.tag, ".cells"}, cells, e.cells);
      check_eq({e.tag, ".gen"}, 64'(generation), 64'(e.gen));
      check_eq({e.tag, ".flags"}, 64'({load_ready, busy, stable}), 64'(e.flags));
    end
    clr_inputs();
  endtask

  task automatic drive_load(input int r, input logic [7:0] v);
    load_valid = 1'b1; load_row = 3'(r); load_data = v;
  endtask

  function automatic logic [63:0] setrow(input logic [63:0] b, input int r, input logic [7:0] v);
    b[r*8 +: 8] = v;
    return b;
  endfunction

  // Independent reference generation step.
  function automatic logic [63:0] life_next(input logic [63:0] b);
    logic [63:0] nb;
    int n, rr, cc;
    nb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr; cc = c + dc;
`ifdef LIFE_TORUS_EN
            rr = (rr + 8) % 8; cc = (cc + 8) % 8;
`else
            if (rr < 0 || rr > 7 || cc < 0 || cc > 7) continue;
`endif
            n += int'(b[rr*8+cc]);
          end
        end
        nb[r*8+c] = (n == 3) || (b[r*8+c] == 1'b1 && n == 2);
      end
    end
    return nb;
  endfunction

  logic [63:0] horiz, vert, blk, brd, model, nxt, glider, glider_sh;
  logic [15:0] g;
  bit          halted;

  initial begin
    rst = 1'b1; load_row = '0; load_data = '0; ticks_per_gen = 16'd1;
    clr_inputs();
    horiz = setrow('0, 3, 8'b0001_1100);
    vert  = setrow(setrow(setrow('0, 2, 8'b0000_1000), 3, 8'b0000_1000), 4, 8'b0000_1000);
    blk   = setrow(setrow('0, 1, 8'b0000_0110), 2, 8'b0000_0110);

    @(posedge clk); #1;
    push_exp("reset", '0, 16'd0, F_IDLE); rst = 1'b1; step(); rst = 1'b0;

    // Blinker, one generation per cycle
    drive_load(3, 8'b0001_1100); push_exp("blk_load", horiz, 16'd0, F_IDLE); step();
    start = 1'b1; push_exp("blink_start", horiz, 16'd0, F_RUN); step();
    push_exp("blink_g1", vert, 16'd1, F_RUN);
    push_exp("blink_g2", horiz, 16'd2, F_RUN);
    push_exp("blink_g3", vert, 16'd3, F_RUN);
    for (int i = 0; i < 3; i++) step();
    stop = 1'b1; push_exp("blink_stop", vert, 16'd3, F_IDLE); step();

    // Four-cycle period; a load attempted mid-run must be ignored
    ticks_per_gen = 16'd4;
    start = 1'b1; push_exp("t4_start", vert, 16'd3, F_RUN); step();
    for (int i = 1; i <= 12; i++)
      push_exp($sformatf("t4_c%0d", i), (i < 4) ? vert : (i < 8) ? horiz : (i < 12) ? vert : horiz,
               16'(3 + i / 4), F_RUN);
    for (int i = 1; i <= 12; i++) begin
      if (i == 2) drive_load(0, 8'hFF);
      step();
    end
    stop = 1'b1; push_exp("t4_stop", horiz, 16'd6, F_IDLE); step();

    // Stop at cycle 6 freezes the board in IDLE
    start = 1'b1; push_exp("s6_start", horiz, 16'd6, F_RUN); step();
    for (int i = 1; i <= 7; i++)
      push_exp($sformatf("s6_c%0d", i), (i < 4) ? horiz : vert, (i < 4) ? 16'd6 : 16'd7,
               (i < 6) ? F_RUN : F_IDLE);
    for (int i = 1; i <= 7; i++) begin
      if (i == 6) stop = 1'b1;
      step();
    end

    // Reset in the middle of a run
    start = 1'b1; push_exp("rr_start", vert, 16'd7, F_RUN); step();
    push_exp("rr_c1", vert, 16'd7, F_RUN); step();
    rst = 1'b1; push_exp("rr_reset", '0, 16'd0, F_IDLE); step(); rst = 1'b0;

    // Block still life halts on the first update
    ticks_per_gen = 16'd1;
    drive_load(1, 8'b0000_0110); push_exp("blk_r1", setrow('0, 1, 8'b0000_0110), 16'd0, F_IDLE); step();
    drive_load(2, 8'b0000_0110); push_exp("blk_r2", blk, 16'd0, F_IDLE); step();
    start = 1'b1; push_exp("blk_start", blk, 16'd0, F_RUN); step();
    push_exp("blk_halt", blk, 16'd0, F_HALT); step();
    push_exp("blk_hold", blk, 16'd0, F_HALT); step();
    drive_load(7, 8'h81); push_exp("halt_load", setrow(blk, 7, 8'h81), 16'd0, F_IDLE); step();
    start = 1'b1; stop = 1'b1; push_exp("start_stop", setrow(blk, 7, 8'h81), 16'd0, F_IDLE); step();

    // Empty board with ticks_per_gen = 0
    rst = 1'b1; push_exp("rst2", '0, 16'd0, F_IDLE); step(); rst = 1'b0;
    ticks_per_gen = 16'd0;
    start = 1'b1; push_exp("empty_start", '0, 16'd0, F_RUN); step();
    push_exp("empty_halt", '0, 16'd0, F_HALT); step();

    // Start together with a load in IDLE
    rst = 1'b1; push_exp("rst3", '0, 16'd0, F_IDLE); step(); rst = 1'b0;
    drive_load(3, 8'b0001_1100); start = 1'b1; push_exp("ld_start", horiz, 16'd0, F_RUN); step();
    push_exp("ld_start_g1", vert, 16'd1, F_RUN); step();
    stop = 1'b1; push_exp("ld_start_stop", vert, 16'd1, F_IDLE); step();

    // Glider approaching the right edge
    rst = 1'b1; push_exp("rst4", '0, 16'd0, F_IDLE); step(); rst = 1'b0;
    ticks_per_gen = 16'd1;
    glider    = setrow(setrow(setrow('0, 1, 8'b0100_0000), 2, 8'b1000_0000), 3, 8'b1110_0000);
    glider_sh = setrow(setrow(setrow('0, 2, 8'b1000_0000), 3, 8'b0000_0001), 4, 8'b1100_0001);
    drive_load(1, 8'b0100_0000); push_exp("gl_r1", setrow('0, 1, 8'b0100_0000), 16'd0, F_IDLE); step();
    drive_load(2, 8'b1000_0000); push_exp("gl_r2", setrow(setrow('0, 1, 8'b0100_0000), 2, 8'b1000_0000), 16'd0, F_IDLE); step();
    drive_load(3, 8'b1110_0000); push_exp("gl_r3", glider, 16'd0, F_IDLE); step();
    start = 1'b1; push_exp("gl_start", glider, 16'd0, F_RUN); step();
    model = glider; g = 16'd0; halted = 1'b0;
    for (int i = 0; i < 24 && !halted; i++) begin
      nxt = life_next(model);
      if (nxt == model) begin
        halted = 1'b1;
        push_exp($sformatf("gl_halt%0d", i), model, g, F_HALT);
      end else begin
        model = nxt; g++;
        push_exp($sformatf("gl_g%0d", g), model, g, F_RUN);
      end
      step();
`ifdef LIFE_TORUS_EN
      if (i == 3) check_eq("torus_wrap", cells, glider_sh);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_stepper.md
# life_stepper

Generation engine for the Game of Life board. Holds a ROWS×COLS cell array and loads an initial pattern one row per cycle. Once started, it advances the board one generation every `ticks_per_gen` cycles and halts automatically when the pattern becomes stable. It consumes per-cell neighbour counts produced by one `bit_counter` per cell and drives the board to the display stage.

## Interface
- `ROWS`, default 8: board height, ≥3.
- `COLS`, default 8: board width, ≥3.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `load_valid`  in  1: row write request.
- `load_row`  in  $clog2(ROWS): row index for the write.
- `load_data`  in  COLS: row contents; bit c is column c.
- `load_ready`  out  1: high when the state is not RUN.
- `start`  in  1: single-cycle pulse that begins running.
- `stop`  in  1: single-cycle pulse that aborts to IDLE.
- `ticks_per_gen`  in  16: cycles per generation; 0 is treated as 1.
- `cells`  out  ROWS*COLS: current board; bit r*COLS+c is row r, column c.
- `generation`  out  16: count of generations that changed the board.
- `busy`  out  1: high in RUN.
- `stable`  out  1: high in HALT.

## Operation
- States are IDLE, RUN and HALT. Reset enters IDLE with `cells`=0, `generation`=0, tick counter=0, `busy`=0, `stable`=0.
- A load is accepted on `load_valid & load_ready`. It writes the row at the next edge.
  - A load in HALT also moves the state to IDLE and clears `stable`.
  - A load in RUN is ignored.
- `start` in IDLE or HALT moves the state to RUN and clears the tick counter and `stable`. `generation` is not cleared; only `rst` clears it.
- In RUN the tick counter increments each cycle. When it equals max(`ticks_per_gen`,1)−1, the update edge occurs:
  - The counter returns to 0.
  - The next board is computed for every cell: next = (n==3) | (alive & n==2), where n is the 0–8 neighbour count.
  - If the next board differs from the current one, `cells` takes the next board and `generation` increments, wrapping from 16'hFFFF to 0.
  - If the next board is identical, `cells` is unchanged, `generation` is unchanged and the state moves to HALT.
- `stop` in RUN returns to IDLE and keeps the current `cells`. `stop` in IDLE or HALT moves to IDLE.
- Priority: `rst` > `stop` > update edge > `start` > load.
  - `start` together with `load_valid` in IDLE: the row is written and the state enters RUN on the same edge.
  - `start` together with `stop`: `stop` wins.
- `ticks_per_gen` is sampled every cycle. Changing it mid-generation takes effect on the next compare.
- Border handling (out-of-board neighbours) is defined under Configuration.

## Timing
- `load_ready`, `busy` and `stable` are decoded from the state register.
- Latency from `start` to the first update edge is `ticks_per_gen` cycles; with `ticks_per_gen`≤1 it is 1 cycle.
- The next board is computed combinationally from `cells` and registered at the update edge. There is no pipelining: one generation per update edge.
- `rst` asserted mid-RUN takes effect at the next edge and fully restores reset values.

## Configuration
- `LIFE_TORUS_EN` defined: the board wraps toroidally. Row −1 is row ROWS−1 and column COLS maps to column 0, including corner neighbours.
- `LIFE_TORUS_EN` undefined: every cell outside the board reads as dead.

## Structure
- Package `life_pkg` holds the state enum (IDLE/RUN/HALT), the default board dimensions and the `TICK_W`=16 width constant.
- One sub-module, `life_cell`:
  - Gathers a cell's eight neighbours and counts them with `bit_counter`.
  - Outputs the next-state bit.
  - It is instantiated ROWS×COLS times in a generate loop. Neighbour index wrapping or zeroing is done in that loop, under the macro.

## Test plan
- Blinker, 8×8: load row 3 = 8'b0001_1100 with all other rows 0, `ticks_per_gen`=1, pulse `start`.
  - After 1 cycle, rows 2, 3 and 4 each equal 8'b0000_1000 and `generation`=1.
  - After 2 cycles the board is back to the horizontal blinker and `generation`=2.
  - HALT is never entered.
- Block: load rows 1 and 2 = 8'b0000_0110, then `start`.
  - After the first update edge `stable`=1 and `busy`=0.
  - `cells` and `generation`=0 are unchanged.
- Empty board: `start` with all rows 0 gives `stable`=1 after 1 cycle.
- Tick period: blinker with `ticks_per_gen`=4 updates exactly at cycles 4, 8 and 12 after `start`.
- Control:
  - `stop` at cycle 6 of a blinker run returns to IDLE with `load_ready`=1 and the board frozen.
  - A load attempted during RUN leaves the board unchanged.
  - `rst` mid-RUN zeroes all outputs.
- Torus (`LIFE_TORUS_EN`): a glider crossing the column COLS−1 edge reappears at column 0 after 4 generations, shifted by one row. Without the macro it decays into a block, and HALT is reached.
